// File: rtl/rs232_pkg.sv
// Shared constants and state type for the RS232 transmitter and receiver-side status logic.
package rs232_pkg;
    localparam int DIV_FAST   = 217;
    localparam int DIV_SLOW   = 1302;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_BITS = 10;
    localparam int TICK_W     = 11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;
endpackage

// File: rtl/rs232_transmitter_if.sv
// CPU-side write port and status of the RS232 transmitter, plus the serial line.
interface rs232_transmitter_if;
    logic       fsel;
    logic       start;
    logic [7:0] data;
    logic       rdy;
    logic       busy;
    logic [2:0] level;
    logic       TxD;

    modport master (output fsel, start, data, input rdy, busy, level, TxD);
    modport slave  (input fsel, start, data, output rdy, busy, level, TxD);
endinterface

// File: rtl/rs232_transmitter_fifo.sv
// Byte FIFO feeding the transmitter; pointers wrap modulo DEPTH, occupancy kept in a separate count.
module rs232_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even if a pop frees a slot on the same edge.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/rs232_transmitter.sv
// Buffered 8N1 transmitter, LSB first. States: IDLE = line high, waiting for a queued byte;
// SEND = shifting {stop, byte, start} out, reloading straight from the FIFO between frames.
module rs232_transmitter #(
    parameter int DIV_FAST   = rs232_pkg::DIV_FAST,
    parameter int DIV_SLOW   = rs232_pkg::DIV_SLOW,
    parameter int FIFO_DEPTH = rs232_pkg::FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    rs232_transmitter_if.slave bus
);
    import rs232_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TICK_W-1:0] DIV_F = TICK_W'(DIV_FAST);
    localparam logic [TICK_W-1:0] DIV_S = TICK_W'(DIV_SLOW);

    tx_state_t         state;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] div;
    logic [3:0]        bitcnt;
    logic [9:0]        shreg;
    logic              txd;
    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic              pop;
    logic [CW-1:0]     count;
    logic              bit_end;
    logic              frame_end;

    assign bit_end   = (tick == div - TICK_W'(1));
    assign frame_end = bit_end && (bitcnt == 4'(FRAME_BITS - 1));
    assign pop       = !empty && ((state == IDLE) || frame_end);

    rs232_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.start),
        .pop   (pop),
        .din   (bus.data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            tick   <= '0;
            div    <= DIV_F;
            bitcnt <= '0;
            shreg  <= '1;
            txd    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shreg  <= {1'b1, head, 1'b0};
                        div    <= bus.fsel ? DIV_F : DIV_S;
                        tick   <= '0;
                        bitcnt <= '0;
                        txd    <= 1'b0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    txd  <= shreg[0];
                    tick <= tick + TICK_W'(1);
                    if (frame_end) begin
                        // Back-to-back frames: next start bit follows the stop bit with no gap.
                        if (!empty) begin
                            shreg  <= {1'b1, head, 1'b0};
                            div    <= bus.fsel ? DIV_F : DIV_S;
                            tick   <= '0;
                            bitcnt <= '0;
                            txd    <= 1'b0;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (bit_end) begin
                        shreg  <= {1'b1, shreg[9:1]};
                        txd    <= shreg[1];
                        tick   <= '0;
                        bitcnt <= bitcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.TxD   = txd;
    assign bus.rdy   = !full;
    assign bus.busy  = (state != IDLE) || (count != '0);
    assign bus.level = 3'(count);
endmodule
